// File: rtl/snow64_float_mul_pipe_pkg.sv
// snow64_float_mul_pipe_pkg: shared constants, field macros and result classification for the lane-parallel float multiplier.
`define SNOW64_FMUL_SIGN(x, e, m) x[(e)+(m)]
`define SNOW64_FMUL_EXP(x, e, m) x[(e)+(m)-1 -: (e)]
`define SNOW64_FMUL_MANT(x, e, m) x[(m)-1:0]
package snow64_float_mul_pipe_pkg;
  function automatic int bias_of(input int e);
    return (1 << (e - 1)) - 1;
  endfunction
  function automatic int max_enc_exp(input int e);
    return (1 << e) - 2;
  endfunction
  function automatic int lane_w(input int e, input int m);
    return 1 + e + m;
  endfunction
  typedef enum logic [1:0] {RES_NORMAL, RES_ZERO, RES_UNF, RES_OVF} res_kind_e;
endpackage

// File: rtl/snow64_float_mul_pipe_if.sv
// snow64_float_mul_pipe_if: operand/result handshake bundle shared by the multiplier and its issuing unit.
interface snow64_float_mul_pipe_if
  import snow64_float_mul_pipe_pkg::*;
#(
  parameter int EXP_WIDTH  = 8,
  parameter int MANT_WIDTH = 7,
  parameter int NUM_LANES  = 4,
  parameter int TAG_WIDTH  = 4
);
  localparam int W = lane_w(EXP_WIDTH, MANT_WIDTH);
  logic                   in_valid;
  logic                   in_ready;
  logic [NUM_LANES*W-1:0] in_a;
  logic [NUM_LANES*W-1:0] in_b;
  logic [NUM_LANES-1:0]   in_lane_en;
  logic [TAG_WIDTH-1:0]   in_tag;
  logic                   out_valid;
  logic                   out_ready;
  logic [NUM_LANES*W-1:0] out_data;
  logic [TAG_WIDTH-1:0]   out_tag;
  logic [NUM_LANES-1:0]   out_ovf;
  logic [NUM_LANES-1:0]   out_unf;
  modport master (
    output in_valid, in_a, in_b, in_lane_en, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag, out_ovf, out_unf
  );
  modport slave (
    input  in_valid, in_a, in_b, in_lane_en, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag, out_ovf, out_unf
  );
endinterface

// File: rtl/snow64_float_mul_lane.sv
// snow64_float_mul_lane: one lane's unpack/multiply, normalise and pack stages.
// SNOW64_FLOAT_MUL_PIPE_ROUND_NEAREST_EVEN_EN selects round-to-nearest-even instead of truncation.
module snow64_float_mul_lane
  import snow64_float_mul_pipe_pkg::*;
#(
  parameter int EXP_WIDTH  = 8,
  parameter int MANT_WIDTH = 7
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  advance,
  input  logic                                  en,
  input  logic [lane_w(EXP_WIDTH,MANT_WIDTH)-1:0] a,
  input  logic [lane_w(EXP_WIDTH,MANT_WIDTH)-1:0] b,
  output logic [lane_w(EXP_WIDTH,MANT_WIDTH)-1:0] data,
  output logic                                  ovf,
  output logic                                  unf
);
  localparam int E = EXP_WIDTH;
  localparam int M = MANT_WIDTH;
  localparam int W = lane_w(E, M);
  // Normalised product keeps only the bits below the leading one that pack actually consumes.
`ifdef SNOW64_FLOAT_MUL_PIPE_ROUND_NEAREST_EVEN_EN
  localparam int PW = 2 * M + 1;
`else
  localparam int PW = M;
`endif
  typedef struct packed {
    logic              s;
    logic signed [E+1:0] e;
    logic [2*M+1:0]    p;
    logic              z;
  } s1_t;
  typedef struct packed {
    logic              s;
    logic signed [E+1:0] e;
    logic [PW-1:0]     p;
    logic              z;
  } s2_t;
  s1_t s1_d, s1_q;
  s2_t s2_d, s2_q;
  logic signed [E+1:0] e3;
  logic [M-1:0] frac;
  res_kind_e kind;
  logic [W-1:0] data_d;
`ifdef SNOW64_FLOAT_MUL_PIPE_ROUND_NEAREST_EVEN_EN
  logic [M:0] rounded;
`endif
  always_comb begin
    s1_d.s = `SNOW64_FMUL_SIGN(a, E, M) ^ `SNOW64_FMUL_SIGN(b, E, M);
    s1_d.e = (E+2)'(`SNOW64_FMUL_EXP(a, E, M)) + (E+2)'(`SNOW64_FMUL_EXP(b, E, M)) - (E+2)'(bias_of(E));
    s1_d.p = {1'b1, `SNOW64_FMUL_MANT(a, E, M)} * {1'b1, `SNOW64_FMUL_MANT(b, E, M)};
    s1_d.z = !en || `SNOW64_FMUL_EXP(a, E, M) == '0 || `SNOW64_FMUL_EXP(b, E, M) == '0;
    s2_d.s = s1_q.s;
    s2_d.e = s1_q.e + (E+2)'(s1_q.p[2*M+1]);
    s2_d.p = PW'((s1_q.p[2*M+1] ? s1_q.p : s1_q.p << 1) >> (2 * M + 1 - PW));
    s2_d.z = s1_q.z;
`ifdef SNOW64_FLOAT_MUL_PIPE_ROUND_NEAREST_EVEN_EN
    rounded = {1'b0, s2_q.p[2*M:M+1]} + (M+1)'(s2_q.p[M] && (|s2_q.p[M-1:0] || s2_q.p[M+1]));
    frac = rounded[M-1:0];
    e3 = s2_q.e + (E+2)'(rounded[M]);
`else
    frac = s2_q.p;
    e3 = s2_q.e;
`endif
    kind = s2_q.z ? RES_ZERO :
           e3 <= 0 ? RES_UNF :
           e3 > $signed((E+2)'(max_enc_exp(E))) ? RES_OVF : RES_NORMAL;
    data_d = kind == RES_OVF    ? {s2_q.s, E'(max_enc_exp(E)), {M{1'b1}}} :
             kind == RES_NORMAL ? {s2_q.s, e3[E-1:0], frac} : {s2_q.s, {(E+M){1'b0}}};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
      data <= '0;
      ovf  <= 1'b0;
      unf  <= 1'b0;
    end else if (advance) begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      data <= data_d;
      ovf  <= kind == RES_OVF;
      unf  <= kind == RES_UNF;
    end
  end
endmodule

// File: rtl/snow64_float_mul_pipe.sv
// snow64_float_mul_pipe: 3-stage lane-parallel float multiplier with shared valid/ready and tag.
// SNOW64_FLOAT_MUL_PIPE_ROUND_NEAREST_EVEN_EN enables round-to-nearest-even in every lane.
module snow64_float_mul_pipe
  import snow64_float_mul_pipe_pkg::*;
#(
  parameter int EXP_WIDTH  = 8,
  parameter int MANT_WIDTH = 7,
  parameter int NUM_LANES  = 4,
  parameter int TAG_WIDTH  = 4
) (
  input logic                   clk,
  input logic                   rst_n,
  snow64_float_mul_pipe_if.slave bus
);
  localparam int W = lane_w(EXP_WIDTH, MANT_WIDTH);
  logic advance;
  logic v1, v2;
  logic [TAG_WIDTH-1:0] t1, t2;
  // Whole pipe stalls only when the output register is full and not being drained.
  assign advance = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = advance;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1            <= 1'b0;
      v2            <= 1'b0;
      bus.out_valid <= 1'b0;
      t1            <= '0;
      t2            <= '0;
      bus.out_tag   <= '0;
    end else if (advance) begin
      v1            <= bus.in_valid;
      v2            <= v1;
      bus.out_valid <= v2;
      t1            <= bus.in_tag;
      t2            <= t1;
      bus.out_tag   <= t2;
    end
  end
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    snow64_float_mul_lane #(
      .EXP_WIDTH (EXP_WIDTH),
      .MANT_WIDTH(MANT_WIDTH)
    ) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .advance(advance),
      .en     (bus.in_lane_en[i]),
      .a      (bus.in_a[i*W +: W]),
      .b      (bus.in_b[i*W +: W]),
      .data   (bus.out_data[i*W +: W]),
      .ovf    (bus.out_ovf[i]),
      .unf    (bus.out_unf[i])
    );
  end
endmodule

// File: tb/tb_snow64_float_mul_pipe.sv
// tb_snow64_float_mul_pipe: scoreboard bench with directed bfloat16 vectors for the lane-parallel multiplier.
module tb_snow64_float_mul_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  snow64_float_mul_pipe_if #(.EXP_WIDTH(8), .MANT_WIDTH(7), .NUM_LANES(4), .TAG_WIDTH(4)) bus ();
  snow64_float_mul_pipe #(.EXP_WIDTH(8), .MANT_WIDTH(7), .NUM_LANES(4), .TAG_WIDTH(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );
  typedef struct {
    logic [63:0] data;
    logic [3:0]  tag;
    logic [3:0]  ovf;
    logic [3:0]  unf;
    bit          chk_lat;
    time         t;
  } exp_t;
  exp_t q[$];
  int n_chk = 0;
  int n_fail = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask
  function automatic logic [63:0] v4(input logic [15:0] l0, l1, l2, l3);
    return {l3, l2, l1, l0};
  endfunction
  task automatic send(input logic [63:0] a, b, input logic [3:0] en, tag,
                      input logic [63:0] d, input logic [3:0] ovf, unf, input bit lat);
    bit ok;
    int w;
    exp_t e;
    bus.in_valid = 1'b1;
    bus.in_a = a;
    bus.in_b = b;
    bus.in_lane_en = en;
    bus.in_tag = tag;
    w = 0;
    do begin
      @(negedge clk);
      ok = bus.in_ready;
      @(posedge clk);
      w++;
    end while (!ok && w < 100);
    chk("send_accept", 64'(ok), 64'd1);
    if (ok) begin
      e.data = d; e.tag = tag; e.ovf = ovf; e.unf = unf; e.chk_lat = lat; e.t = $time;
      q.push_back(e);
    end
    #1 bus.in_valid = 1'b0;
  endtask
  task automatic drain();
    int w = 0;
    while (q.size() != 0 && w < 60) begin
      @(posedge clk);
      w++;
    end
    chk("drain_empty", 64'(q.size()), 64'd0);
  endtask
  bit stalled_prev = 1'b0;
  logic [63:0] held_data;
  logic [3:0] held_tag;
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.out_valid) begin
      if (stalled_prev) begin
        chk("stall_data_stable", bus.out_data, held_data);
        chk("stall_tag_stable", 64'(bus.out_tag), 64'(held_tag));
      end
      if (bus.out_ready) begin
        chk("unexpected_out", 64'(q.size() != 0), 64'd1);
        if (q.size() != 0) begin
          e = q.pop_front();
          chk("data", bus.out_data, e.data);
          chk("tag", 64'(bus.out_tag), 64'(e.tag));
          chk("ovf", 64'(bus.out_ovf), 64'(e.ovf));
          chk("unf", 64'(bus.out_unf), 64'(e.unf));
          if (e.chk_lat) chk("latency", 64'($time - e.t), 64'd25);
        end
      end
      stalled_prev = !bus.out_ready;
      held_data = bus.out_data;
      held_tag = bus.out_tag;
    end else stalled_prev = 1'b0;
  end
  logic [15:0] rnd_exp;
  initial begin
`ifdef SNOW64_FLOAT_MUL_PIPE_ROUND_NEAREST_EVEN_EN
    rnd_exp = 16'h3FC2;
`else
    rnd_exp = 16'h3FC1;
`endif
    bus.in_valid = 1'b0;
    bus.in_a = '0;
    bus.in_b = '0;
    bus.in_lane_en = '0;
    bus.in_tag = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_data", bus.out_data, 64'd0);
    chk("rst_out_tag", 64'(bus.out_tag), 64'd0);
    chk("rst_flags", 64'({bus.out_ovf, bus.out_unf}), 64'd0);
    rst_n = 1'b1;
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;
    send(v4(16'h3F80, 16'hBF80, 16'h3FC0, 16'h0000), v4(16'h4000, 16'h4000, 16'h3FC0, 16'h4000),
         4'hF, 4'd1, v4(16'h4000, 16'hC000, 16'h4010, 16'h0000), 4'h0, 4'h0, 1'b1);
    send(v4(16'h7F00, 16'h0080, 16'h8080, 16'h3F80), v4(16'h4000, 16'h3F00, 16'h3F00, 16'h3F80),
         4'hF, 4'd2, v4(16'h7F7F, 16'h0000, 16'h8000, 16'h3F80), 4'b0001, 4'b0110, 1'b1);
    send(v4(16'h3FC0, 16'h3F80, 16'h3F80, 16'h3F80), v4(16'h3F81, 16'h3F80, 16'h3F80, 16'h3F80),
         4'hF, 4'd3, v4(rnd_exp, 16'h3F80, 16'h3F80, 16'h3F80), 4'h0, 4'h0, 1'b1);
    send({4{16'h4000}}, {4{16'h4000}}, 4'b0101, 4'd4,
         v4(16'h4080, 16'h0000, 16'h4080, 16'h0000), 4'h0, 4'h0, 1'b1);
    drain();
    @(posedge clk);
    #1;
    fork
      for (int k = 0; k < 8; k++)
        send(v4(16'h4000, 16'h4000, 16'h4000, 16'h4000),
             v4(16'h3F80 + 16'(k), 16'h3F81 + 16'(k), 16'h3F82 + 16'(k), 16'h3F83 + 16'(k)), 4'hF, 4'(k),
             v4(16'h4000 + 16'(k), 16'h4001 + 16'(k), 16'h4002 + 16'(k), 16'h4003 + 16'(k)), 4'h0, 4'h0, 1'b0);
      begin
        repeat (4) @(posedge clk);
        #1 bus.out_ready = 1'b0;
        @(negedge clk);
        chk("stall_out_valid", 64'(bus.out_valid), 64'd1);
        chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
        repeat (4) @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join
    drain();
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    for (int k = 0; k < 3; k++)
      send({4{16'h3F80}}, {4{16'h4000}}, 4'hF, 4'(9 + k), {4{16'h4000}}, 4'h0, 4'h0, 1'b0);
    chk("pre_rst_out_valid", 64'(bus.out_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("async_rst_out_data", bus.out_data, 64'd0);
    q.delete();
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    send({4{16'h3F80}}, {4{16'h3F80}}, 4'hF, 4'd12, {4{16'h3F80}}, 4'h0, 4'h0, 1'b1);
    drain();
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial begin
    #50000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
